fetch_unit: RTL and testbench

- IF stage of the 5-stage RV32 pipeline, directly upstream of decode and driven by the hazard/stall controller.
- Generates the fetch PC and runs the instruction-bus handshake (iready_n).
- Buffers returned instructions in a 2-entry queue and drives the IF/ID pipeline register.
- Honours ID stalls and redirects from EX branch, CSR trap/return and ID early-branch, discarding wrong-path fetches, including a bus transfer already in flight.

---
 rtl/fetch_unit.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : IF stage of the 5-stage RV32 pipeline. Generates the fetch PC,
//             runs the instruction-bus request/ready handshake, buffers up to
//             two returned instructions and drives the IF/ID register.
//             Redirects discard wrong-path work, including a transfer that
//             is already in flight on the bus.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_ID,
   input  logic        branch_PC_contral,
   input  logic [31:0] branch_target,
   input  logic        csr_PC_contral,
   input  logic [31:0] csr_target,
   input  logic        branch_PC_early_contral,
   input  logic [31:0] early_target,
   output logic        ireq,
   output logic [31:0] iaddr,
   input  logic [31:0] idata,
   input  logic        iready_n,
   output logic [31:0] pc_IF_ID,
   output logic [31:0] instr_IF_ID,
   output logic        valid_IF_ID,
   output logic [1:0]  buf_count
);

   localparam logic [1:0] c_QUEUE_FULL = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_fpc;
   logic [31:0] r_drain_addr;

   // Two-entry circular queue of {pc, instr}
   logic [31:0] r_q_pc    [2];
   logic [31:0] r_q_instr [2];
   logic        r_head;
   logic [1:0]  r_count;
   logic [1:0]  w_count_nxt;
   logic        w_wr_idx;

   logic [31:0] r_pc_if_id;
   logic [31:0] r_instr_if_id;
   logic        r_valid_if_id;

   logic        w_ireq;
   logic [31:0] w_iaddr;
   logic        w_any_redirect;
   logic        w_redirect;
   logic [31:0] w_target_raw;
   logic [31:0] w_target;
   logic        w_complete;
   logic        w_fetch_data;
   logic        w_bypass;
   logic        w_push;
   logic        w_pop;

   // Redirect selection: EX branch beats CSR beats ID early branch; targets
   // are forced word aligned. Redirects are meaningless in IDLE.
   always_comb begin
      w_any_redirect = branch_PC_contral | csr_PC_contral | branch_PC_early_contral;
      w_redirect     = (r_state != ST_IDLE) && w_any_redirect;
      if (branch_PC_contral) begin
         w_target_raw = branch_target;
      end else if (csr_PC_contral) begin
         w_target_raw = csr_target;
      end else begin
         w_target_raw = early_target;
      end
      w_target = w_target_raw & 32'hFFFF_FFFC;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and bus request; request depends on registered state only
   always_comb begin
      w_state_nxt = r_state;
      w_ireq      = 1'b0;
      w_iaddr     = r_fpc;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            w_ireq = (r_count < c_QUEUE_FULL);
            // A redirect while a transfer is stalled must let that transfer
            // finish on its original address before the new target goes out.
            if (w_redirect && w_ireq && iready_n) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_ireq  = 1'b1;
            w_iaddr = r_drain_addr;
            if (!iready_n) begin
               w_state_nxt = ST_FETCH;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Data movement decisions for this cycle
   always_comb begin
      w_complete   = w_ireq && !iready_n;
      w_fetch_data = (r_state == ST_FETCH) && w_complete && !w_redirect;
      // Empty queue and a free ID stage: the new word goes straight to IF/ID
      w_bypass     = w_fetch_data && (r_count == 2'd0) && !stall_ID;
      w_push       = w_fetch_data && !w_bypass;
      w_pop        = !w_redirect && !stall_ID && (r_count != 2'd0);
      w_wr_idx     = r_head ^ r_count[0];
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Fetch PC: redirect target, or next sequential word after a good fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fpc <= RESET_PC;
      end else if (w_redirect) begin
         r_fpc <= w_target;
      end else if (w_fetch_data) begin
         r_fpc <= r_fpc + 32'd4;
      end
   end

   // Remember the abandoned address so the bus sees a stable request
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drain_addr <= RESET_PC;
      end else if ((r_state == ST_FETCH) && w_redirect && w_ireq && iready_n) begin
         r_drain_addr <= r_fpc;
      end
   end

   // Queue pointers; a redirect empties the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= 1'b0;
         r_count <= 2'd0;
      end else if (w_redirect) begin
         r_head  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         r_head  <= r_head ^ w_pop;
         r_count <= w_count_nxt;
      end
   end

   // Queue storage; contents are only meaningful under r_count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[w_wr_idx]    <= r_fpc;
         r_q_instr[w_wr_idx] <= idata;
      end
   end

   // IF/ID register: redirect bubble, stall hold, queue head, bypass or bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc_if_id    <= 32'h0000_0000;
         r_instr_if_id <= NOP_INSTR;
         r_valid_if_id <= 1'b0;
      end else if (w_redirect) begin
         r_instr_if_id <= NOP_INSTR;
         r_valid_if_id <= 1'b0;
      end else if (!stall_ID) begin
         if (w_pop) begin
            r_pc_if_id    <= r_q_pc[r_head];
            r_instr_if_id <= r_q_instr[r_head];
            r_valid_if_id <= 1'b1;
         end else if (w_bypass) begin
            r_pc_if_id    <= r_fpc;
            r_instr_if_id <= idata;
            r_valid_if_id <= 1'b1;
         end else begin
            r_instr_if_id <= NOP_INSTR;
            r_valid_if_id <= 1'b0;
         end
      end
   end

   assign ireq        = w_ireq;
   assign iaddr       = w_iaddr;
   assign pc_IF_ID    = r_pc_if_id;
   assign instr_IF_ID = r_instr_if_id;
   assign valid_IF_ID = r_valid_if_id;
   assign buf_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Randomized scoreboard bench for fetch_unit against a
//             queue-based reference model of the fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] c_NOP       = 32'h0000_0013;
   localparam int          c_NCYC      = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_ID;
   logic        branch_PC_contral;
   logic [31:0] branch_target;
   logic        csr_PC_contral;
   logic [31:0] csr_target;
   logic        branch_PC_early_contral;
   logic [31:0] early_target;
   logic        ireq;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        iready_n;
   logic [31:0] pc_IF_ID;
   logic [31:0] instr_IF_ID;
   logic        valid_IF_ID;
   logic [1:0]  buf_count;

   int vectors  = 0;
   int failures = 0;
   bit done     = 1'b0;

   typedef struct packed {
      logic        ireq;
      logic [31:0] iaddr;
      logic [1:0]  cnt;
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];

   fetch_unit #(
      .RESET_PC  (c_RESET_PC),
      .NOP_INSTR (c_NOP)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall_ID                (stall_ID),
      .branch_PC_contral       (branch_PC_contral),
      .branch_target           (branch_target),
      .csr_PC_contral          (csr_PC_contral),
      .csr_target              (csr_target),
      .branch_PC_early_contral (branch_PC_early_contral),
      .early_target            (early_target),
      .ireq                    (ireq),
      .iaddr                   (iaddr),
      .idata                   (idata),
      .iready_n                (iready_n),
      .pc_IF_ID                (pc_IF_ID),
      .instr_IF_ID             (instr_IF_ID),
      .valid_IF_ID             (valid_IF_ID),
      .buf_count               (buf_count)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a bijective scramble of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
   endfunction

   assign idata = (ireq && !iready_n) ? mem_word(iaddr) : 32'hDEAD_BEEF;

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0103;
         1:       return 32'hFFFF_FFFC;
         2:       return 32'hFFFF_FFF9;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Stimulus: phased random traffic
   initial begin
      int busy_pct, stall_pct, redir_pct;
      bit rst_ok;
      rst = 1'b1; stall_ID = 1'b0; iready_n = 1'b0;
      branch_PC_contral = 1'b0; csr_PC_contral = 1'b0; branch_PC_early_contral = 1'b0;
      branch_target = '0; csr_target = '0; early_target = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int cyc = 0; cyc < c_NCYC; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc < 40)        begin busy_pct = 0;  stall_pct = 0;  redir_pct = 0; rst_ok = 0; end
         else if (cyc < 200)  begin busy_pct = 40; stall_pct = 0;  redir_pct = 0; rst_ok = 0; end
         else if (cyc < 400)  begin busy_pct = 0;  stall_pct = 50; redir_pct = 0; rst_ok = 0; end
         else if (cyc < 1400) begin busy_pct = 30; stall_pct = 25; redir_pct = 5; rst_ok = 1; end
         else                 begin busy_pct = 60; stall_pct = 10; redir_pct = 8; rst_ok = 1; end
         iready_n                = ($urandom_range(0, 99) < busy_pct);
         stall_ID                = ($urandom_range(0, 99) < stall_pct);
         branch_PC_contral       = ($urandom_range(0, 99) < redir_pct);
         csr_PC_contral          = ($urandom_range(0, 99) < redir_pct);
         branch_PC_early_contral = ($urandom_range(0, 99) < redir_pct);
         branch_target           = pick_target();
         csr_target              = pick_target();
         early_target            = pick_target();
         rst                     = rst_ok && ($urandom_range(0, 199) == 0);
      end
      @(posedge clk);
      #1 done = 1'b1;
      @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
      $finish;
   end

   // Reference model: fetch stage described as a PC, a FIFO and IF/ID contents
   initial begin
      int          m_state;          // 0 idle, 1 fetching, 2 draining
      logic [31:0] m_fpc, m_drain, tgt;
      logic [31:0] mb_pc[$];
      logic [31:0] mb_ins[$];
      logic        m_v;
      logic [31:0] m_pc, m_ins;
      logic        xfer, redir;
      exp_t        e;
      m_state = 0; m_fpc = c_RESET_PC; m_drain = c_RESET_PC;
      m_v = 1'b0; m_pc = 32'h0; m_ins = c_NOP;
      @(posedge clk);
      while (!done) begin
         @(negedge clk);
         if (done) break;
         e.ireq  = (m_state == 1) ? (mb_pc.size() < 2) : (m_state == 2);
         e.iaddr = (m_state == 2) ? m_drain : m_fpc;
         e.cnt   = 2'(mb_pc.size());
         e.v     = m_v;
         e.pc    = m_pc;
         e.instr = m_ins;
         exp_q.push_back(e);
         if (rst) begin
            m_state = 0; m_fpc = c_RESET_PC; m_drain = c_RESET_PC;
            mb_pc.delete(); mb_ins.delete();
            m_v = 1'b0; m_pc = 32'h0; m_ins = c_NOP;
         end else begin
            xfer  = e.ireq && !iready_n;
            redir = (m_state != 0) &&
                    (branch_PC_contral || csr_PC_contral || branch_PC_early_contral);
            tgt   = branch_PC_contral ? branch_target :
                    csr_PC_contral    ? csr_target    : early_target;
            tgt[1:0] = 2'b00;
            if (m_state == 0) begin
               m_state = 1;
               if (!stall_ID) begin m_v = 1'b0; m_ins = c_NOP; end
            end else if (redir) begin
               mb_pc.delete(); mb_ins.delete();
               m_v = 1'b0; m_ins = c_NOP;
               if (m_state == 1 && e.ireq && iready_n) begin
                  m_drain = e.iaddr;
                  m_state = 2;
               end else if (m_state == 2 && !xfer) begin
                  m_state = 2;
               end else begin
                  m_state = 1;
               end
               m_fpc = tgt;
            end else begin
               if (m_state == 1 && xfer) begin
                  mb_pc.push_back(e.iaddr);
                  mb_ins.push_back(mem_word(e.iaddr));
                  m_fpc = m_fpc + 32'd4;
               end
               if (m_state == 2 && xfer) m_state = 1;
               if (!stall_ID) begin
                  if (mb_pc.size() > 0) begin
                     m_v = 1'b1; m_pc = mb_pc.pop_front(); m_ins = mb_ins.pop_front();
                  end else begin
                     m_v = 1'b0; m_ins = c_NOP;
                  end
               end
            end
         end
      end
   end

   // Monitor: pops one expectation per cycle and compares all DUT outputs
   initial begin
      exp_t e;
      @(posedge clk);
      while (!done) begin
         @(negedge clk);
         if (done) break;
         #2;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
         end else begin
            e = exp_q.pop_front();
            check("ireq",        {31'h0, ireq},        {31'h0, e.ireq});
            check("iaddr",       iaddr,                e.iaddr);
            check("buf_count",   {30'h0, buf_count},   {30'h0, e.cnt});
            check("valid_IF_ID", {31'h0, valid_IF_ID}, {31'h0, e.v});
            check("pc_IF_ID",    pc_IF_ID,             e.pc);
            check("instr_IF_ID", instr_IF_ID,          e.instr);
         end
      end
   end

endmodule
`default_nettype wire
